param_pq: RTL and testbench
===========================

PARAM_PQ -- requirements
Module: param_pq

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning key/data width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, meaning heap capacity in entries; AW = clog2(DEPTH).
REQ-003 SHALL have parameter MIN_MODE, default 0, meaning 0 = max-heap, 1 = min-heap.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 data_valid  input  1  load strobe, one entry per cycle.
REQ-007 data  input  DATA_W  load value.
REQ-008 cmd_valid  input  1  command strobe.
REQ-009 cmd  input  3  command code.
REQ-010 index  input  AW  heap position (0-based) for key-change and delete.
REQ-011 value  input  DATA_W  key for key-change and insert.
REQ-012 busy  output  1  high while a command executes.
REQ-013 RAM_valid  output  1  write strobe to external RAM.
REQ-014 RAM_A  output  AW  RAM write address.
REQ-015 RAM_D  output  DATA_W  RAM write data.
REQ-016 done  output  1  one-cycle pulse at end of write-out.

Function
REQ-017 "Better(a,b)" SHALL mean a>b unsigned when MIN_MODE=0 and a<b when MIN_MODE=1; heap array A[0..DEPTH-1]; children of i are 2i+1 and 2i+2.
REQ-018 Load: in IDLE, each cycle with data_valid=1 SHALL write data to A[count] and increment count; loads are ignored once count=DEPTH.
REQ-019 A command SHALL be accepted only when cmd_valid=1 and busy=0; busy SHALL rise the cycle after acceptance and fall when the FSM returns to IDLE.
REQ-020 FSM states: IDLE, BUILD, SIFT_DOWN, SIFT_UP, WRITE, DONE; at most one compare-and-swap per cycle.
REQ-021 cmd 000 Build: heapify i = count/2-1 down to 0 via SIFT_DOWN; count<2 is a no-op.
REQ-022 SIFT_DOWN SHALL swap with the better child only if strictly better than the parent; on equal children the left child wins.
REQ-023 cmd 001 Extract: A[0] <= A[count-1], count--, SIFT_DOWN from 0; count=0 is a no-op.
REQ-024 cmd 010 Key-improve: if index<count and Better(value, A[index]), A[index] <= value then SIFT_UP; otherwise no-op.
REQ-025 cmd 011 Insert: if count<DEPTH, A[count] <= value, count++, SIFT_UP; full heap is a no-op.
REQ-026 cmd 101 Delete: if index<count, A[index] <= A[count-1], count--, then SIFT_UP if the new value beats its parent, else SIFT_DOWN; index>=count is a no-op.
REQ-027 cmd 100 Write: for i=0..count-1, one per cycle, RAM_valid=1, RAM_A=i, RAM_D=A[i]; done SHALL pulse for one cycle after the last write (immediately if count=0), then IDLE.
REQ-028 Codes 110 and 111 SHALL be no-ops that hold busy for one cycle.
REQ-029 RAM_valid SHALL be low outside WRITE; RAM_A/RAM_D SHALL be 0 when RAM_valid=0.
REQ-030 Loads arriving while busy=1 SHALL be ignored.

Reset
REQ-031 While rst=1: busy=0, RAM_valid=0, RAM_A=0, RAM_D=0, done=0, count=0, FSM=IDLE, all A[] = 0.
REQ-032 Reset asserted mid-command SHALL abort the command immediately with no further RAM writes and no done pulse.

Structure
REQ-033 Package param_pq_pkg SHALL hold command encodings and the FSM state enumeration.
REQ-034 A combinational sub-module param_pq_better(a, b, MIN_MODE) SHALL implement Better() and be instanced for parent/child compares.

Verification
REQ-035 Load 1,2,3; Build; Write -> RAM[0..2] = 3,2,1; one done pulse.
REQ-036 From heap 3,2,1: Extract, Write -> RAM[0..1] = 2,1; Key-improve idx 1 to 9, Write -> 9,2.
REQ-037 Heap 3,2,1: Key-improve idx 0 to 1 -> no change; Delete idx 0 -> heap 2,1.
REQ-038 Full 16-entry heap: Insert 0xFF -> contents unchanged, count 16; empty heap: Insert 5, Write -> RAM[0]=5.
REQ-039 MIN_MODE=1: load 3,1,2; Build; Write -> RAM[0..2] = 1,3,2.
REQ-040 Assert rst during Write of 12 entries -> RAM_valid, busy and done all 0 immediately; no done pulse follows.

Source files
------------

// File: rtl/param_pq_pkg.sv
// Shared command encodings and controller state enumeration for the priority queue.
package param_pq_pkg;

  localparam logic [2:0] CMD_BUILD   = 3'b000;
  localparam logic [2:0] CMD_EXTRACT = 3'b001;
  localparam logic [2:0] CMD_IMPROVE = 3'b010;
  localparam logic [2:0] CMD_INSERT  = 3'b011;
  localparam logic [2:0] CMD_WRITE   = 3'b100;
  localparam logic [2:0] CMD_DELETE  = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BUILD,
    S_SIFT_DOWN,
    S_SIFT_UP,
    S_WRITE,
    S_DONE
  } state_t;

endpackage

// File: rtl/param_pq_better.sv
// Heap ordering compare: win=1 when a should sit above b (greater for max-heap, smaller for min-heap).
// Purely combinational, no backpressure.
module param_pq_better #(
  parameter int DATA_W   = 8,
  parameter int MIN_MODE = 0
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              win
);

  assign win = (MIN_MODE != 0) ? (a < b) : (a > b);

endmodule

// File: rtl/param_pq.sv
// Register-array binary heap with load, build, extract, key-improve, insert, delete and write-out; one swap per cycle.
// Commands are accepted only while idle (busy=0); loads and commands arriving while busy are dropped.
module param_pq
  import param_pq_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int MIN_MODE = 0,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_valid,
  input  logic [DATA_W-1:0] data,
  input  logic              cmd_valid,
  input  logic [2:0]        cmd,
  input  logic [AW-1:0]     index,
  input  logic [DATA_W-1:0] value,
  output logic              busy,
  output logic              RAM_valid,
  output logic [AW-1:0]     RAM_A,
  output logic [DATA_W-1:0] RAM_D,
  output logic              done
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  state_t            state, state_nxt;
  logic [DATA_W-1:0] heap [DEPTH];
  logic [AW:0]       count, last_i;
  logic [AW-1:0]     pos, par, chd, bi, wi;
  logic [AW+1:0]     lft, rgt;
  logic              build_run, down_after, is_wr;
  logic              lft_ok, rgt_ok, idx_ok;
  logic              rgt_win, chd_win, up_win, key_win;
  logic              dn_swap, up_swap, key_ok;

  assign last_i = count - (AW+1)'(1);
  assign lft    = {1'b0, pos, 1'b1};
  assign rgt    = lft + (AW+2)'(1);
  assign par    = (pos - AW'(1)) >> 1;
  assign lft_ok = lft < {1'b0, count};
  assign rgt_ok = rgt < {1'b0, count};
  assign idx_ok = {1'b0, index} < count;
  // Left child is kept on ties: the right one must be strictly better to be picked.
  assign chd    = (rgt_ok && rgt_win) ? rgt[AW-1:0] : lft[AW-1:0];

  param_pq_better #(.DATA_W(DATA_W), .MIN_MODE(MIN_MODE)) u_rl (
    .a(heap[rgt[AW-1:0]]), .b(heap[lft[AW-1:0]]), .win(rgt_win));
  param_pq_better #(.DATA_W(DATA_W), .MIN_MODE(MIN_MODE)) u_dn (
    .a(heap[chd]), .b(heap[pos]), .win(chd_win));
  param_pq_better #(.DATA_W(DATA_W), .MIN_MODE(MIN_MODE)) u_up (
    .a(heap[pos]), .b(heap[par]), .win(up_win));
  param_pq_better #(.DATA_W(DATA_W), .MIN_MODE(MIN_MODE)) u_key (
    .a(value), .b(heap[index]), .win(key_win));

  assign dn_swap = lft_ok && chd_win;
  assign up_swap = (pos != '0) && ({1'b0, pos} < count) && up_win;
  assign key_ok  = idx_ok && key_win;
  assign busy    = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    RAM_valid = 1'b0;
    RAM_A     = '0;
    RAM_D     = '0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          case (cmd)
            CMD_BUILD:   state_nxt = (count[AW:1] != '0) ? S_BUILD : S_DONE;
            CMD_EXTRACT: state_nxt = (count != '0) ? S_SIFT_DOWN : S_DONE;
            CMD_IMPROVE: state_nxt = key_ok ? S_SIFT_UP : S_DONE;
            CMD_INSERT:  state_nxt = (count != FULL) ? S_SIFT_UP : S_DONE;
            CMD_DELETE:  state_nxt = idx_ok ? S_SIFT_UP : S_DONE;
            CMD_WRITE:   state_nxt = (count != '0) ? S_WRITE : S_DONE;
            default:     state_nxt = S_DONE;
          endcase
        end
      end
      S_BUILD: state_nxt = S_SIFT_DOWN;
      S_SIFT_DOWN: begin
        if (!dn_swap) state_nxt = (build_run && bi != '0) ? S_BUILD : S_IDLE;
      end
      // A delete whose moved value does not rise falls through to a sift-down.
      S_SIFT_UP: begin
        if (!up_swap) state_nxt = down_after ? S_SIFT_DOWN : S_IDLE;
      end
      S_WRITE: begin
        RAM_valid = 1'b1;
        RAM_A     = wi;
        RAM_D     = heap[wi];
        if ({1'b0, wi} == last_i) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = is_wr;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) heap[i] <= '0;
      count      <= '0;
      pos        <= '0;
      bi         <= '0;
      wi         <= '0;
      build_run  <= 1'b0;
      down_after <= 1'b0;
      is_wr      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          build_run  <= 1'b0;
          down_after <= 1'b0;
          wi         <= '0;
          if (cmd_valid) begin
            is_wr <= (cmd == CMD_WRITE);
            case (cmd)
              CMD_BUILD: begin
                if (count[AW:1] != '0) begin
                  build_run <= 1'b1;
                  bi        <= count[AW:1] - AW'(1);
                end
              end
              CMD_EXTRACT: begin
                if (count != '0) begin
                  heap[0] <= heap[last_i[AW-1:0]];
                  count   <= last_i;
                  pos     <= '0;
                end
              end
              CMD_IMPROVE: begin
                if (key_ok) begin
                  heap[index] <= value;
                  pos         <= index;
                end
              end
              CMD_INSERT: begin
                if (count != FULL) begin
                  heap[count[AW-1:0]] <= value;
                  pos                 <= count[AW-1:0];
                  count               <= count + (AW+1)'(1);
                end
              end
              CMD_DELETE: begin
                if (idx_ok) begin
                  heap[index] <= heap[last_i[AW-1:0]];
                  count       <= last_i;
                  pos         <= index;
                  down_after  <= 1'b1;
                end
              end
              default: ;
            endcase
          end else if (data_valid && count != FULL) begin
            heap[count[AW-1:0]] <= data;
            count               <= count + (AW+1)'(1);
          end
        end
        S_BUILD: pos <= bi;
        S_SIFT_DOWN: begin
          if (dn_swap) begin
            heap[pos] <= heap[chd];
            heap[chd] <= heap[pos];
            pos       <= chd;
          end else if (build_run && bi != '0) begin
            bi <= bi - AW'(1);
          end
        end
        S_SIFT_UP: begin
          if (up_swap) begin
            heap[pos]  <= heap[par];
            heap[par]  <= heap[pos];
            pos        <= par;
            down_after <= 1'b0;
          end
        end
        S_WRITE: wi <= wi + AW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_param_pq.sv
// Directed vector bench for param_pq: a max-heap instance checked by table, plus a min-heap instance sharing stimulus.
module tb_param_pq;

  localparam logic [2:0] OP_BUILD   = 3'b000;
  localparam logic [2:0] OP_EXTRACT = 3'b001;
  localparam logic [2:0] OP_IMPROVE = 3'b010;
  localparam logic [2:0] OP_INSERT  = 3'b011;
  localparam logic [2:0] OP_WRITE   = 3'b100;
  localparam logic [2:0] OP_DELETE  = 3'b101;
  localparam int NV = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       data_valid = 1'b0;
  logic [7:0] data = 8'd0;
  logic       cmd_valid = 1'b0;
  logic [2:0] cmd = 3'd0;
  logic [3:0] index = 4'd0;
  logic [7:0] value = 8'd0;

  logic       busy, ram_valid, done;
  logic [3:0] ram_a;
  logic [7:0] ram_d;
  logic       busy_m, ram_valid_m, done_m;
  logic [3:0] ram_a_m;
  logic [7:0] ram_d_m;

  int total = 0;
  int bad = 0;
  logic [7:0] cap   [32];
  logic [3:0] cap_a [32];
  logic [7:0] cap_m [32];
  int cap_n = 0, done_n = 0, cap_m_n = 0, done_m_n = 0;
  int keep_n;

  typedef struct {
    string            nm;
    int               nl;
    logic [0:7][7:0]  ld;
    bit               bld;
    bit               hop;
    logic [2:0]       op;
    logic [3:0]       idx;
    logic [7:0]       val;
    int               ne;
    logic [0:7][7:0]  ex;
  } vec_t;

  vec_t vecs [NV];
  logic [0:2][7:0] mex;

  param_pq #(.DATA_W(8), .DEPTH(16), .MIN_MODE(0)) dut (
    .clk(clk), .rst(rst), .data_valid(data_valid), .data(data),
    .cmd_valid(cmd_valid), .cmd(cmd), .index(index), .value(value),
    .busy(busy), .RAM_valid(ram_valid), .RAM_A(ram_a), .RAM_D(ram_d), .done(done));

  param_pq #(.DATA_W(8), .DEPTH(16), .MIN_MODE(1)) dut_min (
    .clk(clk), .rst(rst), .data_valid(data_valid), .data(data),
    .cmd_valid(cmd_valid), .cmd(cmd), .index(index), .value(value),
    .busy(busy_m), .RAM_valid(ram_valid_m), .RAM_A(ram_a_m), .RAM_D(ram_d_m), .done(done_m));

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (ram_valid) begin
      if (cap_n < 32) begin
        cap[cap_n]   = ram_d;
        cap_a[cap_n] = ram_a;
      end
      cap_n++;
    end else begin
      check("ram_idle_zero", {20'd0, ram_a, ram_d}, 32'd0);
    end
    if (done) done_n++;
    if (ram_valid_m) begin
      if (cap_m_n < 32) cap_m[cap_m_n] = ram_d_m;
      cap_m_n++;
    end else begin
      check("ram_idle_zero_min", {20'd0, ram_a_m, ram_d_m}, 32'd0);
    end
    if (done_m) done_m_n++;
  end

  function automatic vec_t mk(input string nm, input int nl, input logic [0:7][7:0] ld,
                              input bit bld, input bit hop, input logic [2:0] op,
                              input logic [3:0] idx, input logic [7:0] val,
                              input int ne, input logic [0:7][7:0] ex);
    vec_t v;
    v.nm = nm; v.nl = nl; v.ld = ld; v.bld = bld; v.hop = hop;
    v.op = op; v.idx = idx; v.val = val; v.ne = ne; v.ex = ex;
    return v;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    data_valid = 1'b0;
    cmd_valid = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ram_valid", 32'(ram_valid), 32'd0);
    check("rst_ram_a", 32'(ram_a), 32'd0);
    check("rst_ram_d", 32'(ram_d), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy_min", 32'(busy_m), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    cap_n = 0; done_n = 0; cap_m_n = 0; done_m_n = 0;
  endtask

  task automatic load(input logic [7:0] v);
    data_valid = 1'b1;
    data = v;
    @(posedge clk); #1;
    data_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || busy_m) && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    check("idle_timeout", 32'(busy || busy_m), 32'd0);
  endtask

  task automatic issue(input logic [2:0] op, input logic [3:0] idx, input logic [7:0] val);
    cmd_valid = 1'b1;
    cmd = op;
    index = idx;
    value = val;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("busy_rise", 32'(busy), 32'd1);
    wait_idle();
  endtask

  task automatic check_out(input string nm, input int ne, input logic [0:7][7:0] ex);
    check({nm, " writes"}, cap_n, ne);
    check({nm, " done_pulses"}, done_n, 1);
    for (int i = 0; i < ne && i < 8; i++) begin
      check($sformatf("%s data%0d", nm, i), 32'(cap[i]), 32'(ex[i]));
      check($sformatf("%s addr%0d", nm, i), 32'(cap_a[i]), i);
    end
  endtask

  initial begin
    vecs[0]  = mk("build3", 3, {8'd1, 8'd2, 8'd3, 40'd0}, 1'b1, 1'b0, OP_BUILD, 4'd0, 8'd0,
                  3, {8'd3, 8'd2, 8'd1, 40'd0});
    vecs[1]  = mk("build7", 7, {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd0}, 1'b1, 1'b0, OP_BUILD, 4'd0, 8'd0,
                  7, {8'd7, 8'd5, 8'd6, 8'd4, 8'd2, 8'd1, 8'd3, 8'd0});
    vecs[2]  = mk("eq_children", 3, {8'd1, 8'd5, 8'd5, 40'd0}, 1'b1, 1'b0, OP_BUILD, 4'd0, 8'd0,
                  3, {8'd5, 8'd1, 8'd5, 40'd0});
    vecs[3]  = mk("extract", 3, {8'd1, 8'd2, 8'd3, 40'd0}, 1'b1, 1'b1, OP_EXTRACT, 4'd0, 8'd0,
                  2, {8'd2, 8'd1, 48'd0});
    vecs[4]  = mk("improve", 3, {8'd1, 8'd2, 8'd3, 40'd0}, 1'b1, 1'b1, OP_IMPROVE, 4'd1, 8'd9,
                  3, {8'd9, 8'd3, 8'd1, 40'd0});
    vecs[5]  = mk("improve_worse", 3, {8'd1, 8'd2, 8'd3, 40'd0}, 1'b1, 1'b1, OP_IMPROVE, 4'd0, 8'd1,
                  3, {8'd3, 8'd2, 8'd1, 40'd0});
    vecs[6]  = mk("improve_oob", 3, {8'd1, 8'd2, 8'd3, 40'd0}, 1'b1, 1'b1, OP_IMPROVE, 4'd3, 8'd9,
                  3, {8'd3, 8'd2, 8'd1, 40'd0});
    vecs[7]  = mk("delete_root", 3, {8'd1, 8'd2, 8'd3, 40'd0}, 1'b1, 1'b1, OP_DELETE, 4'd0, 8'd0,
                  2, {8'd2, 8'd1, 48'd0});
    vecs[8]  = mk("delete_last", 3, {8'd1, 8'd2, 8'd3, 40'd0}, 1'b1, 1'b1, OP_DELETE, 4'd2, 8'd0,
                  2, {8'd3, 8'd2, 48'd0});
    vecs[9]  = mk("delete_oob", 3, {8'd1, 8'd2, 8'd3, 40'd0}, 1'b1, 1'b1, OP_DELETE, 4'd5, 8'd0,
                  3, {8'd3, 8'd2, 8'd1, 40'd0});
    vecs[10] = mk("delete_up", 6, {8'd10, 8'd5, 8'd9, 8'd1, 8'd2, 8'd8, 16'd0}, 1'b1, 1'b1, OP_DELETE, 4'd3, 8'd0,
                  5, {8'd10, 8'd8, 8'd9, 8'd5, 8'd2, 24'd0});
    vecs[11] = mk("insert", 3, {8'd1, 8'd2, 8'd3, 40'd0}, 1'b1, 1'b1, OP_INSERT, 4'd0, 8'd5,
                  4, {8'd5, 8'd3, 8'd1, 8'd2, 32'd0});
    vecs[12] = mk("extract_empty", 0, 64'd0, 1'b0, 1'b1, OP_EXTRACT, 4'd0, 8'd0,
                  0, 64'd0);
    vecs[13] = mk("build_one", 1, {8'd7, 56'd0}, 1'b1, 1'b0, OP_BUILD, 4'd0, 8'd0,
                  1, {8'd7, 56'd0});
    vecs[14] = mk("nop110", 3, {8'd1, 8'd2, 8'd3, 40'd0}, 1'b1, 1'b1, 3'b110, 4'd0, 8'd0,
                  3, {8'd3, 8'd2, 8'd1, 40'd0});
    vecs[15] = mk("nop111", 3, {8'd1, 8'd2, 8'd3, 40'd0}, 1'b0, 1'b1, 3'b111, 4'd0, 8'd0,
                  3, {8'd1, 8'd2, 8'd3, 40'd0});

    for (int k = 0; k < NV; k++) begin
      do_reset();
      for (int i = 0; i < vecs[k].nl; i++) load(vecs[k].ld[i]);
      if (vecs[k].bld) issue(OP_BUILD, 4'd0, 8'd0);
      if (vecs[k].hop) issue(vecs[k].op, vecs[k].idx, vecs[k].val);
      cap_n = 0; done_n = 0;
      issue(OP_WRITE, 4'd0, 8'd0);
      check_out(vecs[k].nm, vecs[k].ne, vecs[k].ex);
    end

    // Extract followed by key-improve on the shrunken heap.
    do_reset();
    load(8'd1); load(8'd2); load(8'd3);
    issue(OP_BUILD, 4'd0, 8'd0);
    issue(OP_EXTRACT, 4'd0, 8'd0);
    issue(OP_IMPROVE, 4'd1, 8'd9);
    cap_n = 0; done_n = 0;
    issue(OP_WRITE, 4'd0, 8'd0);
    check_out("extract_improve", 2, {8'd9, 8'd2, 48'd0});

    // Loads presented while a command is running are dropped.
    do_reset();
    load(8'd1); load(8'd2); load(8'd3);
    cmd_valid = 1'b1; cmd = OP_BUILD;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    data_valid = 1'b1; data = 8'h77;
    for (int n = 0; n < 100 && busy; n++) begin
      @(posedge clk); #1;
    end
    data_valid = 1'b0;
    check("busy_load_timeout", 32'(busy), 32'd0);
    wait_idle();
    cap_n = 0; done_n = 0;
    issue(OP_WRITE, 4'd0, 8'd0);
    check_out("load_while_busy", 3, {8'd3, 8'd2, 8'd1, 40'd0});

    // Full heap: extra load and insert are both ignored.
    do_reset();
    for (int i = 0; i < 16; i++) load(8'(i * 7 + 3));
    load(8'hEE);
    issue(OP_INSERT, 4'd0, 8'hFF);
    cap_n = 0; done_n = 0;
    issue(OP_WRITE, 4'd0, 8'd0);
    check("full writes", cap_n, 16);
    check("full done_pulses", done_n, 1);
    for (int i = 0; i < 16; i++)
      check($sformatf("full data%0d", i), 32'(cap[i]), 32'(8'(i * 7 + 3)));

    do_reset();
    issue(OP_INSERT, 4'd0, 8'd5);
    cap_n = 0; done_n = 0;
    issue(OP_WRITE, 4'd0, 8'd0);
    check_out("insert_empty", 1, {8'd5, 56'd0});

    // Min-heap instance.
    do_reset();
    load(8'd3); load(8'd1); load(8'd2);
    issue(OP_BUILD, 4'd0, 8'd0);
    cap_m_n = 0; done_m_n = 0;
    issue(OP_WRITE, 4'd0, 8'd0);
    mex = {8'd1, 8'd3, 8'd2};
    check("min writes", cap_m_n, 3);
    check("min done_pulses", done_m_n, 1);
    for (int i = 0; i < 3; i++)
      check($sformatf("min data%0d", i), 32'(cap_m[i]), 32'(mex[i]));

    // Reset in the middle of a 12-entry write-out.
    do_reset();
    for (int i = 0; i < 12; i++) load(8'(i + 1));
    cap_n = 0; done_n = 0;
    cmd_valid = 1'b1; cmd = OP_WRITE;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort ram_valid", 32'(ram_valid), 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort writes_before", cap_n, 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("abort data%0d", i), 32'(cap[i]), i + 1);
    keep_n = cap_n;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("abort writes_after", cap_n, keep_n);
    check("abort no_done", done_n, 0);
    check("abort idle", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
